// File: rtl/cond_status_unit.sv
`default_nettype none
// ============================================================================
//  Module   : cond_status_unit
//  Brief    : NZCV status register, outstanding flag-setter tracking and
//             multi-lane ARM condition-code evaluation with a registered,
//             valid-qualified execute/skip result and perf counters.
//  Revision : 1.0  initial release
// ============================================================================
module cond_status_unit #(
    parameter int LANES  = 2,
    parameter int PEND_W = 2,
    parameter int CNT_W  = 16,
    parameter int BYPASS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 flag_we,
    input  logic [3:0]           flag_in,
    input  logic                 flag_pend_set,
    input  logic                 cond_valid,
    input  logic [4*LANES-1:0]   cond,
    output logic                 cond_ready,
    output logic [LANES-1:0]     check,
    output logic                 check_valid,
    output logic [3:0]           flags,
    output logic                 pend_ovf,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     exec_cnt,
    output logic [CNT_W-1:0]     skip_cnt
);

    localparam logic [PEND_W-1:0] c_pend_max = {PEND_W{1'b1}};

    logic [3:0]        r_flags;
    logic [PEND_W-1:0] r_pend;
    logic              r_pend_ovf;
    logic [LANES-1:0]  r_check;
    logic              r_check_valid;
    logic [CNT_W-1:0]  r_exec_cnt;
    logic [CNT_W-1:0]  r_skip_cnt;

    logic [3:0]        w_flag_eff;
    logic [PEND_W-1:0] w_pend_eff;
    logic              w_pend_full;
    logic              w_pend_inc;
    logic              w_accept;
    logic [LANES-1:0]  w_res;
    logic [CNT_W-1:0]  w_pop;
    logic [CNT_W-1:0]  w_nonpop;

    // Evaluate one ARM condition code against an {N,Z,C,V} flag vector.
    function automatic logic f_eval(input logic [3:0] code, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (code)
            4'h0:    f_eval = z;
            4'h1:    f_eval = !z;
            4'h2:    f_eval = c;
            4'h3:    f_eval = !c;
            4'h4:    f_eval = n;
            4'h5:    f_eval = !n;
            4'h6:    f_eval = v;
            4'h7:    f_eval = !v;
            4'h8:    f_eval = c && !z;
            4'h9:    f_eval = !c || z;
            4'hA:    f_eval = (n == v);
            4'hB:    f_eval = (n != v);
            4'hC:    f_eval = !z && (n == v);
            4'hD:    f_eval = z || (n != v);
            4'hE:    f_eval = 1'b1;
            default: f_eval = 1'b0;
        endcase
    endfunction

    // A flag write in flight this cycle can be forwarded straight into evaluation.
    assign w_flag_eff = ((BYPASS != 0) && flag_we) ? flag_in : r_flags;

    // A committing write retires one outstanding setter; a write with nothing
    // outstanding is a single-cycle setter and leaves the count at zero.
    assign w_pend_eff  = (flag_we && (r_pend != '0)) ? (r_pend - PEND_W'(1)) : r_pend;
    assign w_pend_full = (w_pend_eff == c_pend_max);
    assign w_pend_inc  = flag_pend_set && !w_pend_full;

    // A same-cycle pend_set belongs to a younger instruction, so it is not
    // part of the readiness test.
    assign cond_ready = ((BYPASS != 0) ? (w_pend_eff == '0) : (r_pend == '0)) && !flush;
    assign w_accept   = cond_valid && cond_ready;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign w_res[gi] = f_eval(cond[4*gi +: 4], w_flag_eff);
        end
    endgenerate

    // Number of lanes that evaluated true and false for this request.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            w_pop = w_pop + CNT_W'(w_res[i]);
        end
        w_nonpop = CNT_W'(LANES) - w_pop;
    end

    // Architectural flags: committed writes land even while flushing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= 4'b0000;
        end else if (flag_we) begin
            r_flags <= flag_in;
        end
    end

    // Outstanding setter count; a flush discards every uncommitted setter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
        end else if (flush) begin
            r_pend <= '0;
        end else if (w_pend_inc) begin
            r_pend <= w_pend_eff + PEND_W'(1);
        end else begin
            r_pend <= w_pend_eff;
        end
    end

    // Sticky record of a setter that could not be tracked because the count was full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_ovf <= 1'b0;
        end else if (flag_pend_set && w_pend_full && !flush) begin
            r_pend_ovf <= 1'b1;
        end
    end

    // Result register: check holds its last value, valid pulses per accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_check       <= '0;
            r_check_valid <= 1'b0;
        end else begin
            r_check_valid <= w_accept;
            if (w_accept) begin
                r_check <= w_res;
            end
        end
    end

    // Performance counters, wrapping; clear wins over a same-cycle accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exec_cnt <= '0;
            r_skip_cnt <= '0;
        end else if (cnt_clr) begin
            r_exec_cnt <= '0;
            r_skip_cnt <= '0;
        end else if (w_accept) begin
            r_exec_cnt <= r_exec_cnt + w_pop;
            r_skip_cnt <= r_skip_cnt + w_nonpop;
        end
    end

    assign flags       = r_flags;
    assign pend_ovf    = r_pend_ovf;
    assign check       = r_check;
    assign check_valid = r_check_valid;
    assign exec_cnt    = r_exec_cnt;
    assign skip_cnt    = r_skip_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cond_status_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_cond_status_unit
//  Brief    : Self-checking bench for cond_status_unit (bypassed and
//             non-bypassed instances sharing one stimulus bus).
//  Revision : 1.0  initial release
// ============================================================================
module tb_cond_status_unit;

    localparam int LANES  = 2;
    localparam int PEND_W = 2;
    localparam int CNT_W  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, flush, flag_we, flag_pend_set, cond_valid, cnt_clr;
    logic [3:0]         flag_in;
    logic [4*LANES-1:0] cond;

    logic               cond_ready, check_valid, pend_ovf;
    logic [LANES-1:0]   check;
    logic [3:0]         flags;
    logic [CNT_W-1:0]   exec_cnt, skip_cnt;

    logic               nb_cond_ready, nb_check_valid, nb_pend_ovf;
    logic [LANES-1:0]   nb_check;
    logic [3:0]         nb_flags;
    logic [CNT_W-1:0]   nb_exec_cnt, nb_skip_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [LANES-1:0] sb[$];

    cond_status_unit #(.LANES(LANES), .PEND_W(PEND_W), .CNT_W(CNT_W), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .flag_we(flag_we), .flag_in(flag_in),
        .flag_pend_set(flag_pend_set), .cond_valid(cond_valid), .cond(cond),
        .cond_ready(cond_ready), .check(check), .check_valid(check_valid),
        .flags(flags), .pend_ovf(pend_ovf), .cnt_clr(cnt_clr),
        .exec_cnt(exec_cnt), .skip_cnt(skip_cnt)
    );

    cond_status_unit #(.LANES(LANES), .PEND_W(PEND_W), .CNT_W(CNT_W), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .flush(flush), .flag_we(flag_we), .flag_in(flag_in),
        .flag_pend_set(flag_pend_set), .cond_valid(cond_valid), .cond(cond),
        .cond_ready(nb_cond_ready), .check(nb_check), .check_valid(nb_check_valid),
        .flags(nb_flags), .pend_ovf(nb_pend_ovf), .cnt_clr(cnt_clr),
        .exec_cnt(nb_exec_cnt), .skip_cnt(nb_skip_cnt)
    );

    // Reference condition decode written from the ARM condition table.
    function automatic logic ref_cond(input logic [3:0] code, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (code)
            4'h0: return z;
            4'h1: return ~z;
            4'h2: return c;
            4'h3: return ~c;
            4'h4: return n;
            4'h5: return ~n;
            4'h6: return v;
            4'h7: return ~v;
            4'h8: return c & ~z;
            4'h9: return ~c | z;
            4'hA: return ~(n ^ v);
            4'hB: return n ^ v;
            4'hC: return ~z & ~(n ^ v);
            4'hD: return z | (n ^ v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        flush = 0; flag_we = 0; flag_in = 4'h0; flag_pend_set = 0;
        cond_valid = 0; cond = '0; cnt_clr = 0;
    endtask

    task automatic do_reset;
        rst = 1;
        idle_inputs();
        tick();
        tick();
        rst = 0;
        sb.delete();
    endtask

    task automatic test_reset;
        rst = 1;
        idle_inputs();
        #1;
        n_cmp++; if (cond_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", cond_ready); end
        tick();
        n_cmp++; if (flags !== 4'h0) begin n_bad++; $display("FAIL reset_flags: got %h want 0", flags); end
        n_cmp++; if (check !== 2'b00) begin n_bad++; $display("FAIL reset_check: got %b want 00", check); end
        n_cmp++; if (check_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", check_valid); end
        n_cmp++; if (pend_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", pend_ovf); end
        n_cmp++; if (exec_cnt !== 4'h0 || skip_cnt !== 4'h0) begin n_bad++; $display("FAIL reset_cnt: got %h/%h want 0/0", exec_cnt, skip_cnt); end
        n_cmp++; if (nb_cond_ready !== 1'b1 || nb_check_valid !== 1'b0) begin n_bad++; $display("FAIL reset_nb: got rdy=%b vld=%b want 1/0", nb_cond_ready, nb_check_valid); end
        rst = 0;
    endtask

    task automatic test_decode;
        logic [LANES-1:0] e;
        do_reset();
        for (int f = 0; f < 16; f++) begin
            flag_we = 1; flag_in = 4'(f); cond_valid = 0;
            tick();
            flag_we = 0;
            n_cmp++; if (flags !== 4'(f)) begin n_bad++; $display("FAIL decode_flags: got %h want %h", flags, 4'(f)); end
            for (int c = 0; c < 16; c += 2) begin
                cond = {4'(c + 1), 4'(c)}; cond_valid = 1;
                sb.push_back({ref_cond(4'(c + 1), 4'(f)), ref_cond(4'(c), 4'(f))});
                tick();
                n_cmp++; if (check_valid !== 1'b1) begin n_bad++; $display("FAIL decode_valid: flags=%h cond=%h got %b want 1", f, cond, check_valid); end
                n_cmp++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL decode_sb: queue empty, got check=%b", check); end
                else begin
                    e = sb.pop_front();
                    if (check !== e) begin n_bad++; $display("FAIL decode_check: flags=%h cond=%h got %b want %b", f, cond, check, e); end
                end
            end
            cond_valid = 0;
            tick();
            n_cmp++; if (check_valid !== 1'b0) begin n_bad++; $display("FAIL decode_pulse: got %b want 0", check_valid); end
        end
    endtask

    task automatic test_stall_bypass;
        logic [LANES-1:0] e;
        do_reset();
        flag_pend_set = 1;
        tick();
        flag_pend_set = 0;
        cond = 8'h00; cond_valid = 1;
        #1;
        n_cmp++; if (cond_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready: got %b want 0", cond_ready); end
        tick();
        n_cmp++; if (check_valid !== 1'b0) begin n_bad++; $display("FAIL stall_valid: got %b want 0", check_valid); end
        flag_we = 1; flag_in = 4'b0100;
        #1;
        n_cmp++; if (cond_ready !== 1'b1) begin n_bad++; $display("FAIL bypass_ready: got %b want 1", cond_ready); end
        sb.push_back(2'b11);
        tick();
        flag_we = 0; cond_valid = 0;
        n_cmp++; if (check_valid !== 1'b1) begin n_bad++; $display("FAIL bypass_valid: got %b want 1", check_valid); end
        n_cmp++;
        if (sb.size() == 0) begin n_bad++; $display("FAIL bypass_sb: queue empty, got check=%b", check); end
        else begin
            e = sb.pop_front();
            if (check !== e) begin n_bad++; $display("FAIL bypass_check: got %b want %b", check, e); end
        end
        n_cmp++; if (flags !== 4'b0100) begin n_bad++; $display("FAIL bypass_flags: got %b want 0100", flags); end
    endtask

    task automatic test_nobypass;
        do_reset();
        flag_pend_set = 1;
        tick();
        flag_pend_set = 0;
        cond = 8'h00; cond_valid = 1;
        #1;
        n_cmp++; if (nb_cond_ready !== 1'b0) begin n_bad++; $display("FAIL nb_stall: got %b want 0", nb_cond_ready); end
        tick();
        flag_we = 1; flag_in = 4'b0100;
        #1;
        n_cmp++; if (nb_cond_ready !== 1'b0) begin n_bad++; $display("FAIL nb_we_ready: got %b want 0", nb_cond_ready); end
        tick();
        flag_we = 0;
        #1;
        n_cmp++; if (nb_check_valid !== 1'b0) begin n_bad++; $display("FAIL nb_early_valid: got %b want 0", nb_check_valid); end
        n_cmp++; if (nb_flags !== 4'b0100) begin n_bad++; $display("FAIL nb_flags: got %b want 0100", nb_flags); end
        n_cmp++; if (nb_cond_ready !== 1'b1) begin n_bad++; $display("FAIL nb_ready: got %b want 1", nb_cond_ready); end
        tick();
        cond_valid = 0;
        n_cmp++; if (nb_check_valid !== 1'b1) begin n_bad++; $display("FAIL nb_valid: got %b want 1", nb_check_valid); end
        n_cmp++; if (nb_check !== 2'b11) begin n_bad++; $display("FAIL nb_check: got %b want 11", nb_check); end
    endtask

    task automatic test_overflow;
        do_reset();
        flag_pend_set = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (cond_ready !== 1'b0) begin n_bad++; $display("FAIL ovf_inc_ready: step %0d got %b want 0", i, cond_ready); end
        end
        n_cmp++; if (pend_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_early: got %b want 0", pend_ovf); end
        tick();
        flag_pend_set = 0;
        #1;
        n_cmp++; if (pend_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", pend_ovf); end
        n_cmp++; if (cond_ready !== 1'b0) begin n_bad++; $display("FAIL ovf_hold: got %b want 0", cond_ready); end
        flag_we = 1; flag_in = 4'b0010;
        tick();
        flag_we = 0;
        #1;
        n_cmp++; if (cond_ready !== 1'b0) begin n_bad++; $display("FAIL ovf_p2: got %b want 0", cond_ready); end
        flag_we = 1;
        tick();
        flag_we = 0;
        #1;
        n_cmp++; if (cond_ready !== 1'b0) begin n_bad++; $display("FAIL ovf_p1: got %b want 0", cond_ready); end
        flag_we = 1;
        #1;
        n_cmp++; if (cond_ready !== 1'b1) begin n_bad++; $display("FAIL ovf_bypass_ready: got %b want 1", cond_ready); end
        tick();
        flag_we = 0;
        #1;
        n_cmp++; if (cond_ready !== 1'b1) begin n_bad++; $display("FAIL ovf_p0: got %b want 1", cond_ready); end
        n_cmp++; if (pend_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", pend_ovf); end
    endtask

    task automatic test_flush;
        logic [LANES-1:0] e;
        do_reset();
        flag_pend_set = 1;
        tick();
        tick();
        flag_pend_set = 0;
        cond = {4'h1, 4'h0}; cond_valid = 1;
        #1;
        n_cmp++; if (cond_ready !== 1'b0) begin n_bad++; $display("FAIL flush_stall: got %b want 0", cond_ready); end
        tick();
        flush = 1; flag_we = 1; flag_in = 4'b1000;
        #1;
        n_cmp++; if (cond_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready: got %b want 0", cond_ready); end
        tick();
        flush = 0; flag_we = 0;
        #1;
        n_cmp++; if (flags !== 4'b1000) begin n_bad++; $display("FAIL flush_flags: got %b want 1000", flags); end
        n_cmp++; if (check_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b want 0", check_valid); end
        n_cmp++; if (cond_ready !== 1'b1) begin n_bad++; $display("FAIL flush_p0: got %b want 1", cond_ready); end
        sb.push_back(2'b10);
        tick();
        cond_valid = 0;
        n_cmp++; if (check_valid !== 1'b1) begin n_bad++; $display("FAIL flush_accept: got %b want 1", check_valid); end
        n_cmp++;
        if (sb.size() == 0) begin n_bad++; $display("FAIL flush_sb: queue empty, got check=%b", check); end
        else begin
            e = sb.pop_front();
            if (check !== e) begin n_bad++; $display("FAIL flush_check: got %b want %b", check, e); end
        end
    endtask

    task automatic test_rst_midstall;
        logic [LANES-1:0] e;
        do_reset();
        cond = {4'h1, 4'h0}; cond_valid = 1; flag_pend_set = 1;
        #1;
        n_cmp++; if (cond_ready !== 1'b1) begin n_bad++; $display("FAIL younger_pend: got %b want 1", cond_ready); end
        sb.push_back(2'b10);
        tick();
        flag_pend_set = 0;
        n_cmp++;
        if (sb.size() == 0) begin n_bad++; $display("FAIL younger_sb: queue empty, got check=%b", check); end
        else begin
            e = sb.pop_front();
            if (check_valid !== 1'b1 || check !== e) begin n_bad++; $display("FAIL younger_check: got %b/%b want 1/%b", check_valid, check, e); end
        end
        #1;
        n_cmp++; if (cond_ready !== 1'b0) begin n_bad++; $display("FAIL midstall_ready: got %b want 0", cond_ready); end
        rst = 1;
        #1;
        n_cmp++; if (cond_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", cond_ready); end
        n_cmp++; if (check_valid !== 1'b0 || check !== 2'b00) begin n_bad++; $display("FAIL rst_discard: got %b/%b want 0/00", check_valid, check); end
        tick();
        rst = 0; cond_valid = 0;
    endtask

    task automatic test_back_to_back_counters;
        logic [LANES-1:0] e;
        do_reset();
        cond = {4'hF, 4'hE}; cond_valid = 1;
        for (int i = 1; i <= 18; i++) begin
            sb.push_back(2'b01);
            tick();
            n_cmp++; if (check_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid: accept %0d got %b want 1", i, check_valid); end
            n_cmp++;
            if (sb.size() == 0) begin n_bad++; $display("FAIL b2b_sb: queue empty, got check=%b", check); end
            else begin
                e = sb.pop_front();
                if (check !== e) begin n_bad++; $display("FAIL b2b_check: accept %0d got %b want %b", i, check, e); end
            end
            n_cmp++;
            if (exec_cnt !== 4'(i) || skip_cnt !== 4'(i)) begin
                n_bad++; $display("FAIL cnt_value: accept %0d got %0d/%0d want %0d/%0d", i, exec_cnt, skip_cnt, 4'(i), 4'(i));
            end
        end
        cnt_clr = 1;
        sb.push_back(2'b01);
        tick();
        cnt_clr = 0; cond_valid = 0;
        n_cmp++;
        if (sb.size() == 0) begin n_bad++; $display("FAIL clr_sb: queue empty, got check=%b", check); end
        else begin
            e = sb.pop_front();
            if (check_valid !== 1'b1 || check !== e) begin n_bad++; $display("FAIL clr_check: got %b/%b want 1/%b", check_valid, check, e); end
        end
        n_cmp++; if (exec_cnt !== 4'h0 || skip_cnt !== 4'h0) begin n_bad++; $display("FAIL cnt_clr: got %0d/%0d want 0/0", exec_cnt, skip_cnt); end
        tick();
        n_cmp++; if (check_valid !== 1'b0 || exec_cnt !== 4'h0) begin n_bad++; $display("FAIL clr_idle: got %b/%0d want 0/0", check_valid, exec_cnt); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_decode();
        test_stall_bypass();
        test_nobypass();
        test_overflow();
        test_flush();
        test_rst_midstall();
        test_back_to_back_counters();
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL sb_drain: got %0d entries want 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cond_status_unit.md
# cond_status_unit

Parametrised condition-evaluation and status-register block for the pipelined ARM core. It holds the architectural NZCV flags and tracks outstanding flag-setting instructions. It evaluates LANES 4-bit ARM condition codes per request against the current or same-cycle-bypassed flags, and returns registered execute/skip bits with a valid/ready handshake. It sits between the ID/EXE boundary and the EXE stage, and stalls issue while flags are unresolved.

## Interface
- LANES, 2, condition codes evaluated per accepted request (1..8)
- PEND_W, 2, width of outstanding flag-setter counter; max outstanding = 2^PEND_W-1
- CNT_W, 16, width of executed/skipped performance counters
- BYPASS, 1, 1 = flag_in written this cycle is visible to this cycle's evaluation; 0 = register only
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  pipeline flush; squashes younger work
- flag_we  input  1  a flag-setting instruction commits flags this cycle
- flag_in  input  4  committed flags, order {N,Z,C,V}
- flag_pend_set  input  1  a flag-setting instruction issued; flags arrive later via flag_we
- cond_valid  input  1  evaluation request present
- cond  input  4*LANES  condition codes, lane i at [4i+3:4i]
- cond_ready  output  1  request can be accepted this cycle (combinational)
- check  output  LANES  registered per-lane result, 1 = execute
- check_valid  output  1  check holds a fresh result (one-cycle pulse per accept)
- flags  output  4  architectural NZCV register
- pend_ovf  output  1  sticky: pend_set dropped because counter full
- cnt_clr  input  1  synchronous clear of both counters
- exec_cnt  output  CNT_W  lanes evaluated true, cumulative
- skip_cnt  output  CNT_W  lanes evaluated false, cumulative

## Operation
- Effective flags F: flag_in if BYPASS and flag_we, else flags register.
- Decode per lane: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0.
- Flags register: loads flag_in when flag_we, including under flush; otherwise holds.
- Pending counter P. Effective pending E = P-1 if flag_we and P>0, else P.
- Next P = E + flag_pend_set. With flush, next P = 0.
- flag_we with P=0 is legal (single-cycle setter); P stays 0.
- flag_pend_set with E = max: increment dropped, pend_ovf set, sticky until rst.
- cond_ready = (BYPASS ? E==0 : P==0) and !flush.
- flag_pend_set in the same cycle as a request belongs to a younger instruction and never blocks that request.
- Accept = cond_valid & cond_ready. On accept, check <= per-lane results and check_valid <= 1. Otherwise check_valid <= 0 and check holds its last value.
- flush drops check_valid to 0 on the next edge, even if a request was presented.
- Counters on accept: exec_cnt += popcount(results), skip_cnt += LANES - popcount. Both wrap modulo 2^CNT_W.
- cnt_clr has priority over increment: counters go to 0.

## Timing
- Reset values: flags=0000, P=0, check=0, check_valid=0, pend_ovf=0, exec_cnt=0, skip_cnt=0. cond_ready is 1 during reset unless flush is asserted.
- Latency is 1 cycle: request accepted at edge k gives check/check_valid valid after edge k.
- The flags output reflects flag_we one cycle after the write edge. The check bits of a bypassed evaluation already use the new flags.
- Back-to-back accepts every cycle are supported; check_valid stays high continuously.
- rst asserted mid-stall clears P, so cond_ready returns to 1 immediately. Any in-flight check is discarded.

## Test plan
- Reset then all 16 codes across all 16 NZCV values, BYPASS=1, LANES=2: each lane matches the decode list. Includes flags=0101 (Z=1, V=1, N=0) with cond=D giving check=1. check_valid pulses once per accept.
- Stall/bypass: pend_set with P=0 and cond EQ held valid, so cond_ready=0. Then flag_we with flag_in=0100 in the same cycle as the request: accepted that cycle, check=1. flags=0100 on the next cycle.
- BYPASS=0, same sequence: request accepted one cycle after flag_we, check=1.
- Overflow: PEND_W=2, three pend_sets take P to 3. A fourth pend_set without flag_we sets pend_ovf=1 and P stays 3. Three flag_we pulses then restore cond_ready=1.
- Flush: P=2 with a request pending, flush pulse plus flag_we(1000). Next cycle: P=0, flags=1000, check_valid=0. The request is accepted the following cycle.
- Counters: CNT_W=4, LANES=2, 9 accepts of {AL,NV} give exec_cnt=9, skip_cnt=9. Further accepts wrap each counter from 15 to 0. cnt_clr together with an accept leaves both counters at 0.
